// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment font for the seg_scan_595 scanner.
// Contents:
//   seg_state_e  - scan FSM states (idle, load word, shift 16 bits, latch)
//   SEG_WORD_W   - width of one 74HC595 pair word {dp, g..a, sel[7:0]}
//   SEG_BLANK    - segment pattern for an unlit digit
//   seg_font_map - hex nibble -> {g,f,e,d,c,b,a}, active high
package seg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StLatch
    } seg_state_e;

    localparam int unsigned SEG_WORD_W = 16;
    localparam logic [6:0]  SEG_BLANK  = 7'h00;

    function automatic logic [6:0] seg_font_map(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = 7'h3f;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5b;
            4'h3: seg = 7'h4f;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6d;
            4'h6: seg = 7'h7d;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7f;
            4'h9: seg = 7'h6f;
            4'ha: seg = 7'h77;
            4'hb: seg = 7'h7c;
            4'hc: seg = 7'h39;
            4'hd: seg = 7'h5e;
            4'he: seg = 7'h79;
            4'hf: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_595_if.sv
// Display-update bus between the value producer and seg_scan_595.
// Signals:
//   dat        - hex value per digit, digit i at dat[4i+3:4i]
//   dat_en     - digit i shown when 1
//   dot_en     - decimal point of digit i lit when 1
//   upd        - update request level, held by the producer until upd_ack
//   upd_ack    - one-clk pulse: dat/dat_en/dot_en taken into the shadow
//   frame_done - one-clk pulse after the last digit's RCK falls
// Modports: master = producer side, slave = scanner side.
interface seg_scan_595_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] dat;
    logic [NUM_DIGITS-1:0]   dat_en;
    logic [NUM_DIGITS-1:0]   dot_en;
    logic                    upd;
    logic                    upd_ack;
    logic                    frame_done;

    modport master (
        output dat, dat_en, dot_en, upd,
        input  upd_ack, frame_done
    );

    modport slave (
        input  dat, dat_en, dot_en, upd,
        output upd_ack, frame_done
    );
endinterface

// File: rtl/seg_font.sv
// Combinational hex-to-7-segment decoder.
// Ports:
//   hex_i - 4-bit digit value
//   seg_o - {g,f,e,d,c,b,a}, active high
module seg_font
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = seg_font_map(hex_i);
    end
endmodule

// File: rtl/seg_scan_595.sv
// Multiplexed 7-segment scanner driving a cascaded pair of 74HC595s
// (segment byte first, then digit-select byte) over SCK/SER/RCK.
// Optional feature macro: SEG_ZERO_BLANK_EN (leading-zero suppression).
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   bus_io     - update bus (seg_scan_595_if.slave): dat/dat_en/dot_en/upd in,
//                upd_ack/frame_done out
//   seg_rck_o  - 74HC595 RCK
//   seg_sck_o  - 74HC595 SCK
//   seg_din_o  - 74HC595 SER
module seg_scan_595
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned CLK_DIV        = 150,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_595_if.slave    bus_io,
    output logic             seg_rck_o,
    output logic             seg_sck_o,
    output logic             seg_din_o
);
    localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(CLK_DIV - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

    seg_state_e state_q, state_d;
    logic [TickW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [SEG_WORD_W-1:0]   word_q, word_d;
    logic                    rck_q, rck_d;
    logic                    sck_q, sck_d;
    logic                    din_q, din_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] dat_q;
    logic [NUM_DIGITS-1:0]   dat_en_q;
    logic [NUM_DIGITS-1:0]   dot_en_q;

    logic                    tick;
    logic                    cap;
    logic [4*NUM_DIGITS-1:0] eff_dat;
    logic [NUM_DIGITS-1:0]   eff_en;
    logic [NUM_DIGITS-1:0]   eff_dot;
    logic [NUM_DIGITS-1:0]   supp;
    logic [3:0]              cur_nib;
    logic                    cur_en;
    logic                    cur_dot;
    logic                    cur_sup;
    logic                    show;
    logic [6:0]              cur_seg;
    logic [7:0]              seg_byte;
    logic [7:0]              sel_byte;
    logic [SEG_WORD_W-1:0]   word_new;

    assign tick       = (tick_cnt_q == TickMax);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Capture only at the start of a frame so the display never tears.
    assign cap = tick && (state_q == StLoad) && (idx_q == '0) && bus_io.upd;
    assign bus_io.upd_ack    = cap;
    assign bus_io.frame_done = frame_done_q;

    // The word built in the capture clk already uses the new data.
    assign eff_dat = cap ? bus_io.dat    : dat_q;
    assign eff_en  = cap ? bus_io.dat_en : dat_en_q;
    assign eff_dot = cap ? bus_io.dot_en : dot_en_q;

`ifdef SEG_ZERO_BLANK_EN
    logic lead;
    // Walk from the most significant digit; disabled digits do not end the run.
    always_comb begin
        supp = '0;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lead && (!dat_en_q[i] || ((dat_q[4*i +: 4] == 4'h0) && !dot_en_q[i]))) begin
                supp[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    assign supp = '0;
`endif

    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dot = 1'b0;
        cur_sup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nib = eff_dat[4*i +: 4];
                cur_en  = eff_en[i];
                cur_dot = eff_dot[i];
                cur_sup = supp[i];
            end
        end
    end

    seg_font u_seg_font (
        .hex_i (cur_nib),
        .seg_o (cur_seg)
    );

    always_comb begin
        show     = cur_en && !cur_sup;
        seg_byte = show ? {cur_dot, cur_seg} : {1'b0, SEG_BLANK};
        sel_byte = show ? (8'h01 << idx_q) : 8'h00;
        if (SEG_ACTIVE_LOW) seg_byte = ~seg_byte;
        if (DIG_ACTIVE_LOW) sel_byte = ~sel_byte;
        word_new = {seg_byte, sel_byte};
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bit_cnt_d    = bit_cnt_q;
        word_d       = word_q;
        rck_d        = rck_q;
        sck_d        = sck_q;
        din_d        = din_q;
        frame_done_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StLoad;
                end
                StLoad: begin
                    word_d    = word_new;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
                StShift: begin
                    // Even tick: SCK low and present the next bit; odd tick: SCK high.
                    if (!bit_cnt_q[0]) begin
                        sck_d = 1'b0;
                        din_d = word_q[4'd15 - bit_cnt_q[4:1]];
                    end else begin
                        sck_d = 1'b1;
                    end
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) state_d = StLatch;
                end
                StLatch: begin
                    // bit_cnt is 0 on entry (wrapped from 31) and marks the RCK phase.
                    if (bit_cnt_q == 5'd0) begin
                        rck_d     = 1'b1;
                        bit_cnt_d = 5'd1;
                    end else begin
                        rck_d        = 1'b0;
                        bit_cnt_d    = 5'd0;
                        frame_done_d = (idx_q == IdxMax);
                        idx_d        = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
                        state_d      = StLoad;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            idx_q        <= '0;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            rck_q        <= 1'b0;
            sck_q        <= 1'b0;
            din_q        <= 1'b0;
            frame_done_q <= 1'b0;
            dat_q        <= '0;
            dat_en_q     <= '0;
            dot_en_q     <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            idx_q        <= idx_d;
            bit_cnt_q    <= bit_cnt_d;
            word_q       <= word_d;
            rck_q        <= rck_d;
            sck_q        <= sck_d;
            din_q        <= din_d;
            frame_done_q <= frame_done_d;
            if (cap) begin
                dat_q    <= bus_io.dat;
                dat_en_q <= bus_io.dat_en;
                dot_en_q <= bus_io.dot_en;
            end
        end
    end

    assign seg_rck_o = rck_q;
    assign seg_sck_o = sck_q;
    assign seg_din_o = din_q;

endmodule

// File: tb/tb_seg_scan_595.sv
module tb_seg_scan_595;
    logic clk;
    logic rst;
    logic rck4, sck4, din4;
    logic rck8, sck8, din8;

    int checks;
    int failures;
    int cyc;
    int sck4_rises;

    logic [15:0] q4[$];
    logic [15:0] q8[$];
    int          fd4_t[$];
    int          r8_t[$];

    seg_scan_595_if #(.NUM_DIGITS(4)) if4 ();
    seg_scan_595_if #(.NUM_DIGITS(8)) if8 ();

    seg_scan_595 #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus_io    (if4),
        .seg_rck_o (rck4),
        .seg_sck_o (sck4),
        .seg_din_o (din4)
    );

    seg_scan_595 #(
        .NUM_DIGITS     (8),
        .CLK_DIV        (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .bus_io    (if8),
        .seg_rck_o (rck8),
        .seg_sck_o (sck8),
        .seg_din_o (din8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the 74HC595 pair: shift on SCK rise, record the word on RCK rise.
    initial begin
        logic [15:0] sh4, sh8;
        logic sck4_p, rck4_p, sck8_p, rck8_p;
        sh4 = '0; sh8 = '0;
        sck4_p = 1'b0; rck4_p = 1'b0; sck8_p = 1'b0; rck8_p = 1'b0;
        cyc = 0; sck4_rises = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                sh4 = '0;
                sh8 = '0;
            end else begin
                if (sck4 && !sck4_p) begin
                    sh4 = {sh4[14:0], din4};
                    sck4_rises++;
                end
                if (rck4 && !rck4_p) q4.push_back(sh4);
                if (if4.frame_done) fd4_t.push_back(cyc);
                if (sck8 && !sck8_p) sh8 = {sh8[14:0], din8};
                if (rck8 && !rck8_p) begin
                    q8.push_back(sh8);
                    r8_t.push_back(cyc);
                end
            end
            sck4_p = sck4; rck4_p = rck4; sck8_p = sck8; rck8_p = rck8;
        end
    end

    task automatic get_word4(output logic [15:0] w);
        int n;
        n = 0;
        while (q4.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() == 0) begin
            checks++; failures++;
            $display("FAIL get_word4 timeout: got no word, required one within 400 clks");
            w = 16'hxxxx;
        end else begin
            w = q4.pop_front();
        end
    endtask

    task automatic get_word8(output logic [15:0] w);
        int n;
        n = 0;
        while (q8.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL get_word8 timeout: got no word, required one within 400 clks");
            w = 16'hxxxx;
        end else begin
            w = q8.pop_front();
        end
    endtask

    // Waits for upd_ack on the 4-digit bus, then drops upd after the capture edge.
    task automatic ack4(input string name);
        int n;
        n = 0;
        while (!if4.upd_ack && n < 800) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!if4.upd_ack) begin
            failures++;
            $display("FAIL %s ack4 timeout: upd_ack=0 required 1", name);
        end
        @(posedge clk);
        #1 if4.upd = 1'b0;
        @(negedge clk);
        checks++;
        if (if4.upd_ack !== 1'b0) begin
            failures++;
            $display("FAIL %s ack4 width: upd_ack=%b required 0 one clk later", name, if4.upd_ack);
        end
    endtask

    task automatic test_reset;
        logic [15:0] w;
        rst = 1'b1;
        if4.upd = 1'b0; if4.dat = '0; if4.dat_en = '0; if4.dot_en = '0;
        if8.upd = 1'b0; if8.dat = '0; if8.dat_en = '0; if8.dot_en = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rck4, sck4, din4} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outs4: rck/sck/din=%b required 000", {rck4, sck4, din4});
        end
        checks++;
        if ({rck8, sck8, din8} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outs8: rck/sck/din=%b required 000", {rck8, sck8, din8});
        end
        checks++;
        if ({if4.upd_ack, if4.frame_done, if8.upd_ack, if8.frame_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pulses: ack/fd=%b required 0000",
                     {if4.upd_ack, if4.frame_done, if8.upd_ack, if8.frame_done});
        end
        q4.delete(); q8.delete();
        rst = 1'b0;
        get_word4(w);
        checks++;
        if (w !== 16'h00ff) begin
            failures++;
            $display("FAIL reset_blank4: word=%h required 00ff", w);
        end
        get_word8(w);
        checks++;
        if (w !== 16'h00ff) begin
            failures++;
            $display("FAIL reset_blank8: word=%h required 00ff", w);
        end
    endtask

    task automatic test_all_eights;
        logic [15:0] exp8 [8];
        logic [15:0] w;
        int n;
        exp8 = '{16'hfffe, 16'hfffd, 16'hfffb, 16'hfff7,
                 16'hffef, 16'hffdf, 16'hffbf, 16'hff7f};
        if8.dat = 32'h8888_8888; if8.dat_en = 8'hff; if8.dot_en = 8'hff; if8.upd = 1'b1;
        n = 0;
        while (!if8.upd_ack && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!if8.upd_ack) begin
            failures++;
            $display("FAIL eights_ack: upd_ack=0 required 1");
        end
        q8.delete(); r8_t.delete();
        @(posedge clk);
        #1 if8.upd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            get_word8(w);
            checks++;
            if (w !== exp8[i]) begin
                failures++;
                $display("FAIL eights_word%0d: word=%h required %h", i, w, exp8[i]);
            end
        end
        checks++;
        if (r8_t.size() < 8 || (r8_t[1] - r8_t[0]) != 70 || (r8_t[7] - r8_t[6]) != 70) begin
            failures++;
            $display("FAIL eights_rck_period: rck stamps=%p required spacing 70", r8_t);
        end
    endtask

    task automatic test_count;
        logic [15:0] expc [5];
        logic [15:0] w;
        int n;
        expc = '{16'h3ffe, 16'h06fd, 16'h5bfb, 16'h4ff7, 16'h3ffe};
        if4.dat = 16'h3210; if4.dat_en = 4'hf; if4.dot_en = 4'h0; if4.upd = 1'b1;
        ack4("count");
        q4.delete(); fd4_t.delete();
        for (int i = 0; i < 5; i++) begin
            get_word4(w);
            checks++;
            if (w !== expc[i]) begin
                failures++;
                $display("FAIL count_word%0d: word=%h required %h", i, w, expc[i]);
            end
        end
        n = 0;
        while (fd4_t.size() < 2 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fd4_t.size() < 2 || (fd4_t[1] - fd4_t[0]) != 280) begin
            failures++;
            $display("FAIL count_frame_period: frame_done stamps=%p required spacing 280", fd4_t);
        end
    endtask

    task automatic test_disabled;
        logic [15:0] expd [4];
        logic [15:0] w;
        expd = '{16'h3ffe, 16'h06fd, 16'h00ff, 16'h4ff7};
        if4.dat_en = 4'hb; if4.upd = 1'b1;
        ack4("disabled");
        q4.delete();
        for (int i = 0; i < 4; i++) begin
            get_word4(w);
            checks++;
            if (w !== expd[i]) begin
                failures++;
                $display("FAIL disabled_word%0d: word=%h required %h", i, w, expd[i]);
            end
        end
    endtask

    task automatic test_upd_mid_frame;
        logic [15:0] expn [3];
        logic [15:0] w;
        int k;
        expn = '{16'h06fe, 16'h5bfd, 16'h4ffb};
        k = 0;
        w = '0;
        while (w !== 16'h06fd && k < 6) begin
            get_word4(w);
            k++;
        end
        checks++;
        if (w !== 16'h06fd) begin
            failures++;
            $display("FAIL upd_sync: last word=%h required 06fd", w);
        end
        if4.dat = 16'h4321; if4.dat_en = 4'hf; if4.upd = 1'b1;
        k = 0;
        while (!if4.upd_ack && k < 800) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (q4.size() != 2) begin
            failures++;
            $display("FAIL upd_wait: words before ack=%0d required 2", q4.size());
        end
        if (q4.size() >= 2) begin
            checks++;
            if (q4[0] !== 16'h00ff || q4[1] !== 16'h4ff7) begin
                failures++;
                $display("FAIL upd_old_shadow: words=%h %h required 00ff 4ff7", q4[0], q4[1]);
            end
        end
        ack4("upd_mid");
        q4.delete();
        for (int i = 0; i < 3; i++) begin
            get_word4(w);
            checks++;
            if (w !== expn[i]) begin
                failures++;
                $display("FAIL upd_new_word%0d: word=%h required %h", i, w, expn[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [15:0] w;
        int base, n, ack_at, acks;
        get_word4(w);
        base = sck4_rises;
        n = 0;
        while (sck4_rises < base + 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if4.dat = 16'h3210; if4.dat_en = 4'hf; if4.dot_en = 4'h0; if4.upd = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({rck4, sck4, din4} !== 3'b000) begin
            failures++;
            $display("FAIL midshift_abort: rck/sck/din=%b required 000", {rck4, sck4, din4});
        end
        repeat (3) @(negedge clk);
        q4.delete();
        rst = 1'b0;
        n = 0; ack_at = 0; acks = 0;
        while (q4.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (if4.upd_ack) begin
                acks++;
                if (ack_at == 0) ack_at = n;
            end
        end
        if4.upd = 1'b0;
        checks++;
        if (ack_at != 3 || acks != 1) begin
            failures++;
            $display("FAIL midshift_ack: ack at clk %0d count %0d required clk 3 count 1",
                     ack_at, acks);
        end
        checks++;
        if (n != 70 || q4.size() != 1) begin
            failures++;
            $display("FAIL midshift_first_rck: rck at clk %0d words %0d required clk 70 words 1",
                     n, q4.size());
        end
        get_word4(w);
        checks++;
        if (w !== 16'h3ffe) begin
            failures++;
            $display("FAIL midshift_word: word=%h required 3ffe", w);
        end
    endtask

    task automatic test_zero_blank;
        logic [15:0] expz [4];
        logic [15:0] w;
`ifdef SEG_ZERO_BLANK_EN
        expz = '{16'h3ffe, 16'h6dfd, 16'h00ff, 16'h00ff};
`else
        expz = '{16'h3ffe, 16'h6dfd, 16'h3ffb, 16'h3ff7};
`endif
        if4.dat = 16'h0050; if4.dat_en = 4'hf; if4.dot_en = 4'h0; if4.upd = 1'b1;
        ack4("zero_blank");
        q4.delete();
        for (int i = 0; i < 4; i++) begin
            get_word4(w);
            checks++;
            if (w !== expz[i]) begin
                failures++;
                $display("FAIL zero_blank_word%0d: word=%h required %h", i, w, expz[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_all_eights();
        test_count();
        test_disabled();
        test_upd_mid_frame();
        test_reset_mid_shift();
        test_zero_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_595.md
# seg_scan_595

Parametrised multiplexed 7-segment scanner driving a cascaded pair of 74HC595 shift registers (segment byte, then digit-select byte) over a 3-wire serial link. It replaces the fixed 8-digit scanner with a configurable digit count, select polarity and serial rate. It also adds a clock-enable based bit clock instead of a derived clock, and a frame-synchronous update handshake that prevents tearing. It sits between display-producing logic (counters, clocks, debug values) and the board's SEG pins.

## Interface
- NUM_DIGITS, 8, number of scanned digits, 1..8
- CLK_DIV, 150, clk cycles per tick; 150 at 12 MHz gives 80 kHz ticks, 40 kHz SCK
- SEG_ACTIVE_LOW, 0, 1 inverts the whole segment byte (common-anode boards)
- DIG_ACTIVE_LOW, 1, 1 makes a selected digit's select bit 0 and unselected bits 1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dat  in  4*NUM_DIGITS  hex value per digit; digit i at dat[4i+3:4i]
- dat_en  in  NUM_DIGITS  digit i displayed when 1
- dot_en  in  NUM_DIGITS  decimal point of digit i lit when 1
- upd  in  1  update request level; held until upd_ack
- upd_ack  out  1  one-clk pulse: dat/dat_en/dot_en captured into shadow
- frame_done  out  1  one-clk pulse after the last digit's RCK falls
- seg_rck  out  1  74HC595 RCK
- seg_sck  out  1  74HC595 SCK
- seg_din  out  1  74HC595 SER

## Operation
- Shadow registers hold the displayed dat/dat_en/dot_en. Live inputs are ignored except at capture.
- Capture happens only in LOAD for digit 0 while upd=1. In the same clk, upd_ack pulses and the new shadow is used for that digit's word.
- Shift word is 16 bits {dp, g,f,e,d,c,b,a, sel[7:0]}, sent MSB first.
- Font, {g..a}: 0 3f, 1 06, 2 5b, 3 4f, 4 66, 5 6d, 6 7d, 7 07, 8 7f, 9 6f, A 77, b 7c, C 39, d 5e, E 79, F 71.
- Digit select: sel bit i is active for digit i only. Bits ≥ NUM_DIGITS are always inactive.
- Disabled digit (dat_en[i]=0): the sel byte is all-inactive and the segment byte is all-off (dp off too). SEG_ACTIVE_LOW inversion is applied after blanking.
- FSM runs one state step per tick, and the tick is a 1-clk enable every CLK_DIV clks. States:
  - IDLE: go to LOAD.
  - LOAD: build word for digit idx, go to SHIFT, bit counter = 0.
  - SHIFT: 32 ticks. Even tick sets sck=0 and din=word[15-k]. Odd tick sets sck=1. After tick 31, go to LATCH.
  - LATCH: rck=1 for one tick, then rck=0. idx advances, wrapping NUM_DIGITS-1 to 0, then go to LOAD.
- frame_done pulses in the clk where rck falls for idx NUM_DIGITS-1.

## Timing
- Reset values: seg_rck=0, seg_sck=0, seg_din=0, upd_ack=0, frame_done=0. State is IDLE, idx=0, shadow all zero (display blank), tick counter 0.
- Reset mid-shift aborts immediately with no partial RCK. After release: the first tick does IDLE, the second tick does LOAD of digit 0.
- One digit takes 35 ticks (LOAD 1, SHIFT 32, LATCH 2). One frame takes 35·NUM_DIGITS ticks.
- din changes only on the sck falling tick, so it is stable for one full tick before the sck rise.
- upd asserted mid-frame waits until the next digit-0 LOAD; worst-case latency is one frame plus one tick.
- If upd stays high after upd_ack, a capture happens again every frame.
- Counter widths: tick counter is $clog2(CLK_DIV), bit counter 5 bits, idx $clog2(NUM_DIGITS) (minimum 1).

## Configuration
- SEG_ZERO_BLANK_EN defined: leading-zero suppression.
  - Scanning from digit NUM_DIGITS-1 down to 0, an enabled digit whose value is 0 and whose dot is off is blanked as if disabled.
  - Suppression stops at the first nonzero value or lit dot.
  - Digit 0 is never suppressed.
  - Evaluated on the shadow.
- Undefined: every enabled digit shows its value. Zero-blank logic is absent.

## Structure
- Package seg_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, LATCH)
  - SEG_WORD_W=16
  - SEG_BLANK=7'h00
  - font function hex→{g..a}
- Sub-module seg_font: combinational 4-bit to 7-bit decoder, instantiated once on the selected shadow digit.

## Test plan
- NUM_DIGITS=8, CLK_DIV=2, shadow = all 8s with dots on, all enabled → digit 0 word 16'hFFFE (DIG_ACTIVE_LOW). Digit 7 word 16'hFF7F. RCK pulses every 70 clks.
- NUM_DIGITS=4, dat=16'h3210, dat_en=4'hF, dot_en=0 → words 3FFE, 06FD, 5BFB, 4FF7, then wrap to 3FFE. frame_done every 140 ticks.
- dat_en[2]=0 → digit 2 word 16'h00FF (SEG_ACTIVE_LOW=0).
- upd raised during digit 2 → no shadow change until the next digit-0 LOAD. upd_ack is a single-clk pulse there, and digit 0's word reflects the new data.
- rst asserted at SHIFT bit 9 → rck/sck/din go to 0 immediately. After release, the first word shifted is digit 0, and no RCK occurs before it.
- With SEG_ZERO_BLANK_EN, NUM_DIGITS=4, dat=16'h0050 → digits 3 and 2 send 00FF, digit 1 sends 6DFD, digit 0 sends 3FFE.
